// File: rtl/rf_host_pkg.sv
// Shared constants for the RF transceiver host controller: opcodes, status codes,
// command bytes, transfer lengths and the controller state encoding.
package rf_host_pkg;

  localparam logic [2:0] OP_SET_MODE   = 3'd0;
  localparam logic [2:0] OP_WRITE_SAVE = 3'd1;
  localparam logic [2:0] OP_WRITE_VOL  = 3'd2;
  localparam logic [2:0] OP_READ_CFG   = 3'd3;
  localparam logic [2:0] OP_READ_VER   = 3'd4;
  localparam logic [2:0] OP_RESET      = 3'd5;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_AUX_TO = 2'd1;
  localparam logic [1:0] ST_RX_TO  = 2'd2;
  localparam logic [1:0] ST_BAD    = 2'd3;

  localparam logic [7:0] CMD_C0 = 8'hC0;
  localparam logic [7:0] CMD_C1 = 8'hC1;
  localparam logic [7:0] CMD_C2 = 8'hC2;
  localparam logic [7:0] CMD_C3 = 8'hC3;
  localparam logic [7:0] CMD_C4 = 8'hC4;

  localparam logic [1:0] MODE_PROG = 2'b11;

  localparam logic [2:0] TX_LEN_WRITE = 3'd6;
  localparam logic [2:0] TX_LEN_SHORT = 3'd3;
  localparam logic [2:0] RSP_LEN_CFG  = 3'd6;
  localparam logic [2:0] RSP_LEN_VER  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_SWITCH, S_WAIT_AUX, S_SEND, S_RECV, S_RESTORE, S_DONE
  } state_t;

  // Which leg of the operation a WAIT_AUX visit belongs to.
  typedef enum logic [1:0] {PH_PRE, PH_POST, PH_BACK} phase_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_read(input logic [2:0] op);
    return (op == OP_READ_CFG) || (op == OP_READ_VER);
  endfunction

  function automatic logic [2:0] tx_len(input logic [2:0] op);
    return ((op == OP_WRITE_SAVE) || (op == OP_WRITE_VOL)) ? TX_LEN_WRITE : TX_LEN_SHORT;
  endfunction

  function automatic logic [2:0] rx_len(input logic [2:0] op);
    return (op == OP_READ_CFG) ? RSP_LEN_CFG : RSP_LEN_VER;
  endfunction

  function automatic logic [7:0] rsp_hdr(input logic [2:0] op);
    return (op == OP_READ_CFG) ? CMD_C0 : CMD_C3;
  endfunction

  // Byte idx of the outgoing frame; write frames carry cfg MSB byte first after the command.
  function automatic logic [7:0] tx_byte(input logic [2:0] op, input logic [39:0] cfg,
                                         input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (op)
      OP_WRITE_SAVE, OP_WRITE_VOL: begin
        case (idx)
          3'd0: b = (op == OP_WRITE_SAVE) ? CMD_C0 : CMD_C2;
          3'd1: b = cfg[39:32];
          3'd2: b = cfg[31:24];
          3'd3: b = cfg[23:16];
          3'd4: b = cfg[15:8];
          3'd5: b = cfg[7:0];
          default: b = 8'h00;
        endcase
      end
      OP_READ_CFG: b = CMD_C1;
      OP_READ_VER: b = CMD_C3;
      OP_RESET:    b = CMD_C4;
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rf_host_controller_sync_2ff.sv
// Two-flop synchroniser for the asynchronous AUX ready pin.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rf_host_controller.sv
// Host-side sequencer for the RF transceiver: drives M1:M0, waits on AUX, runs the
// UART command frames and restores the pre-operation mode after programming ops.
//
// state      | meaning
// S_IDLE     | ready for a command
// S_SWITCH   | drive target mode pins, arm settle (skipped if already there)
// S_WAIT_AUX | settle countdown, then wait for AUX high with timeout
// S_SEND     | stream the command frame to the UART
// S_RECV     | collect response bytes with inter-byte timeout
// S_RESTORE  | switch back to the saved mode if it was not the programming mode
// S_DONE     | one-cycle response pulse
module rf_host_controller
  import rf_host_pkg::*;
#(
  parameter logic [1:0]  DEFAULT_MODE  = 2'd3,
  parameter int unsigned SETTLE_CYCLES = 31250,
  parameter int unsigned AUX_TIMEOUT   = 1250000,
  parameter int unsigned RX_TIMEOUT    = 625000
) (
  input  logic        internal_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_mode,
  input  logic [39:0] cmd_cfg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        M0,
  output logic        M1,
  input  logic        AUX,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [47:0] rsp_data,
  output logic        busy
);

  localparam int unsigned CNT_MAX = max3(SETTLE_CYCLES, AUX_TIMEOUT, RX_TIMEOUT);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUX_LD    = CNT_W'(AUX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RX_LD     = CNT_W'(RX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic               settling_q, settling_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         saved_q, saved_d;
  logic [1:0]         target_q, target_d;
  logic [2:0]         op_q, op_d;
  logic [2:0]         idx_q, idx_d;
  logic [39:0]        cfg_q, cfg_d;
  logic [1:0]         status_q, status_d;
  logic [47:0]        data_q, data_d;
  logic               aux_s;
  logic               cnt_zero;

  sync_2ff u_aux_sync (
    .clk (internal_clk),
    .rst (rst),
    .d   (AUX),
    .q   (aux_s)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    settling_d = settling_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    saved_d    = saved_q;
    target_d   = target_q;
    op_d       = op_q;
    idx_d      = idx_q;
    cfg_d      = cfg_q;
    status_d   = status_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          cfg_d    = cmd_cfg;
          status_d = ST_OK;
          data_d   = '0;
          idx_d    = '0;
          if (cmd_op > OP_RESET) begin
            status_d = ST_BAD;
            state_d  = S_DONE;
          end else if (cmd_op == OP_SET_MODE) begin
            target_d = cmd_mode;
            state_d  = S_SWITCH;
          end else begin
            target_d = MODE_PROG;
            saved_d  = mode_q;
            state_d  = S_SWITCH;
          end
        end
      end

      S_SWITCH: begin
        phase_d = PH_PRE;
        state_d = S_WAIT_AUX;
        if (target_q == mode_q) begin
          cnt_d      = AUX_LD;
          settling_d = 1'b0;
        end else begin
          mode_d     = target_q;
          cnt_d      = SETTLE_LD;
          settling_d = 1'b1;
        end
      end

      S_WAIT_AUX: begin
        if (settling_q) begin
          if (cnt_zero) begin
            settling_d = 1'b0;
            cnt_d      = AUX_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else if (aux_s) begin
          idx_d = '0;
          case (phase_q)
            PH_PRE:  state_d = (op_q == OP_SET_MODE) ? S_DONE : S_SEND;
            PH_POST: state_d = S_RESTORE;
            default: state_d = S_DONE;
          endcase
        end else if (cnt_zero) begin
          // A restore-leg timeout must not hide an earlier failure.
          if (status_q == ST_OK) status_d = ST_AUX_TO;
          state_d = ((phase_q == PH_BACK) || (op_q == OP_SET_MODE)) ? S_DONE : S_RESTORE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == tx_len(op_q) - 3'd1) begin
            idx_d = '0;
            if (is_read(op_q)) begin
              state_d = S_RECV;
              cnt_d   = RX_LD;
            end else begin
              state_d    = S_WAIT_AUX;
              phase_d    = PH_POST;
              settling_d = 1'b0;
              cnt_d      = AUX_LD;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_RECV: begin
        if (rx_valid) begin
          data_d = data_q | ({rx_data, 40'h0} >> {idx_q, 3'b000});
          if ((idx_q == 3'd0) && (rx_data != rsp_hdr(op_q))) status_d = ST_BAD;
          cnt_d = RX_LD;
          if (idx_q == rx_len(op_q) - 3'd1) state_d = S_RESTORE;
          else idx_d = idx_q + 3'd1;
        end else if (cnt_zero) begin
          if (status_q != ST_BAD) status_d = ST_RX_TO;
          state_d = S_RESTORE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_RESTORE: begin
        if (saved_q != MODE_PROG) begin
          mode_d     = saved_q;
          cnt_d      = SETTLE_LD;
          settling_d = 1'b1;
          phase_d    = PH_BACK;
          state_d    = S_WAIT_AUX;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_PRE;
      settling_q <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= DEFAULT_MODE;
      saved_q    <= DEFAULT_MODE;
      target_q   <= DEFAULT_MODE;
      op_q       <= OP_SET_MODE;
      idx_q      <= '0;
      cfg_q      <= '0;
      status_q   <= ST_OK;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      settling_q <= settling_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      saved_q    <= saved_d;
      target_q   <= target_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      cfg_q      <= cfg_d;
      status_q   <= status_d;
      data_q     <= data_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = ~cmd_ready;
  assign tx_valid   = (state_q == S_SEND);
  assign tx_data    = tx_valid ? tx_byte(op_q, cfg_q, idx_q) : 8'h00;
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_status = status_q;
  assign rsp_data   = data_q;
  assign M1         = mode_q[1];
  assign M0         = mode_q[0];

endmodule

// File: tb/tb_rf_host_controller.sv
// Scoreboard bench for rf_host_controller with shortened timing parameters.
module tb_rf_host_controller;
  import rf_host_pkg::*;

  localparam int SETTLE = 20;
  localparam int AUX_TO = 60;
  localparam int RX_TO  = 40;

  logic        internal_clk = 1'b0;
  logic        rst, cmd_valid, tx_ready, rx_valid, AUX;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_mode;
  logic [39:0] cmd_cfg;
  logic [7:0]  rx_data;
  logic        cmd_ready, tx_valid, M0, M1, rsp_valid, busy;
  logic [7:0]  tx_data;
  logic [1:0]  rsp_status;
  logic [47:0] rsp_data;

  rf_host_controller #(
    .DEFAULT_MODE (2'd3),
    .SETTLE_CYCLES(SETTLE),
    .AUX_TIMEOUT  (AUX_TO),
    .RX_TIMEOUT   (RX_TO)
  ) dut (
    .internal_clk(internal_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mode(cmd_mode), .cmd_cfg(cmd_cfg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .M0(M0), .M1(M1), .AUX(AUX),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .busy(busy)
  );

  initial forever #5 internal_clk = ~internal_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, rsp_cnt = 0, rsp_cyc = 0, acc_cyc = 0, pin_chg = 0, last_rx_cyc = 0;
  bit tx_toggle = 1'b0;
  logic [1:0]  prev_pins = 2'b11;
  logic [51:0] exp_rsp;
  logic [7:0]  tx_q[$];
  logic [51:0] rsp_q[$];
  logic [7:0]  reply_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge internal_clk);
    cyc++;
  end

  initial forever begin
    @(posedge internal_clk);
    #1;
    tx_ready = tx_toggle ? ~tx_ready : 1'b1;
  end

  // Monitors: pin activity, tx byte scoreboard, response scoreboard.
  initial forever begin
    @(negedge internal_clk);
    if ({M1, M0} !== prev_pins) pin_chg++;
    prev_pins = {M1, M0};
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_q.size() == 0) check("tx_extra", 64'(tx_valid), 64'h0);
      else check("tx_byte", 64'(tx_data), 64'(tx_q.pop_front()));
    end
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (rsp_q.size() == 0) check("rsp_extra", 64'(rsp_valid), 64'h0);
      else begin
        exp_rsp = rsp_q.pop_front();
        check("rsp_pins",   64'({M1, M0}),   64'(exp_rsp[51:50]));
        check("rsp_status", 64'(rsp_status), 64'(exp_rsp[49:48]));
        check("rsp_data",   64'(rsp_data),   64'(exp_rsp[47:0]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge internal_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] mode, input logic [39:0] cfg);
    int guard;
    guard = 0;
    @(posedge internal_clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mode  = mode;
    cmd_cfg   = cfg;
    @(negedge internal_clk);
    while (cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge internal_clk);
      guard++;
    end
    check("accept", 64'(cmd_ready), 64'h1);
    @(posedge internal_clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic send_reply();
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 500) begin
      @(negedge internal_clk);
      n++;
    end
    check("tx_drained", 64'(tx_q.size()), 64'h0);
    while (reply_q.size() != 0) begin
      @(posedge internal_clk);
      #1;
      rx_valid    = 1'b1;
      rx_data     = reply_q.pop_front();
      last_rx_cyc = cyc;
      @(posedge internal_clk);
      #1;
      rx_valid = 1'b0;
      @(posedge internal_clk);
      #1;
    end
  endtask

  task automatic wait_rsp(input int start, input int budget);
    int n;
    n = 0;
    while (rsp_cnt == start && n < budget) begin
      @(negedge internal_clk);
      n++;
    end
    check("rsp_arrived", 64'(rsp_cnt), 64'(start + 1));
  endtask

  task automatic push_tx3(input logic [7:0] b);
    repeat (3) tx_q.push_back(b);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    int start, chg0, lat;
    bit flag;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_mode = '0; cmd_cfg = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0; AUX = 1'b1;

    // Reset state
    repeat (2) @(posedge internal_clk);
    @(negedge internal_clk);
    check("rst_m1",         64'(M1),         64'h1);
    check("rst_m0",         64'(M0),         64'h1);
    check("rst_cmd_ready",  64'(cmd_ready),  64'h1);
    check("rst_busy",       64'(busy),       64'h0);
    check("rst_tx_valid",   64'(tx_valid),   64'h0);
    check("rst_rsp_valid",  64'(rsp_valid),  64'h0);
    check("rst_rsp_status", 64'(rsp_status), 64'h0);
    check("rst_rsp_data",   64'(rsp_data),   64'h0);
    @(posedge internal_clk);
    #1;
    rst = 1'b0;
    step(3);

    // READ_VERSION already in mode 3: no pin change, no settle
    push_tx3(CMD_C3);
    reply_q.push_back(8'hC3); reply_q.push_back(8'h32);
    reply_q.push_back(8'h27); reply_q.push_back(8'h02);
    rsp_q.push_back({2'b11, ST_OK, 48'hC33227020000});
    start = rsp_cnt; chg0 = pin_chg;
    issue(OP_READ_VER, 2'd0, 40'h0);
    lat = 0;
    while (tx_valid !== 1'b1 && lat < 100) begin
      @(negedge internal_clk);
      lat++;
    end
    check("rv_no_settle", 64'(lat < SETTLE), 64'h1);
    send_reply();
    wait_rsp(start, 300);
    check("rv_pins_static", 64'(pin_chg - chg0), 64'h0);

    // SET_MODE 0; a stray rx byte outside RECV must be ignored
    rsp_q.push_back({2'b00, ST_OK, 48'h0});
    start = rsp_cnt; chg0 = pin_chg;
    issue(OP_SET_MODE, 2'd0, 40'h0);
    rx_valid = 1'b1; rx_data = 8'hC0;
    step(1);
    rx_valid = 1'b0;
    wait_rsp(start, 300);
    check("sm0_pin_chg", 64'(pin_chg - chg0), 64'h1);

    // WRITE_CFG_VOL from mode 0, AUX raised late, tx_ready toggling
    tx_toggle = 1'b1;
    AUX = 1'b0;
    step(4);
    tx_q.push_back(CMD_C2); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    tx_q.push_back(8'h1A); tx_q.push_back(8'h17); tx_q.push_back(8'h44);
    rsp_q.push_back({2'b00, ST_OK, 48'h0});
    start = rsp_cnt; chg0 = pin_chg;
    issue(OP_WRITE_VOL, 2'd0, 40'h00001A1744);
    flag = 1'b0;
    repeat (SETTLE + 10) begin
      @(negedge internal_clk);
      if (tx_valid === 1'b1) flag = 1'b1;
    end
    check("wv_tx_held_for_aux", 64'(flag), 64'h0);
    check("wv_pins_prog", 64'({M1, M0}), 64'h3);
    AUX = 1'b1;
    wait_rsp(start, 400);
    check("wv_pin_chg", 64'(pin_chg - chg0), 64'h2);
    tx_toggle = 1'b0;

    // READ_CFG with a 5-byte reply -> RX timeout, mode 0 restored
    push_tx3(CMD_C1);
    reply_q.push_back(8'hC0); reply_q.push_back(8'h11); reply_q.push_back(8'h22);
    reply_q.push_back(8'h33); reply_q.push_back(8'h44);
    rsp_q.push_back({2'b00, ST_RX_TO, 48'hC01122334400});
    start = rsp_cnt;
    issue(OP_READ_CFG, 2'd0, 40'h0);
    send_reply();
    wait_rsp(start, RX_TO + SETTLE + 50);
    lat = rsp_cyc - last_rx_cyc;
    check("rc_rx_to_latency", 64'(lat >= RX_TO + SETTLE && lat <= RX_TO + SETTLE + 6), 64'h1);

    // READ_CFG with a bad header -> status 3, all 6 bytes kept
    push_tx3(CMD_C1);
    reply_q.push_back(8'hC2); reply_q.push_back(8'h01); reply_q.push_back(8'h02);
    reply_q.push_back(8'h03); reply_q.push_back(8'h04); reply_q.push_back(8'h05);
    rsp_q.push_back({2'b00, ST_BAD, 48'hC20102030405});
    start = rsp_cnt;
    issue(OP_READ_CFG, 2'd0, 40'h0);
    send_reply();
    wait_rsp(start, 300);

    // RESET op from mode 0
    push_tx3(CMD_C4);
    rsp_q.push_back({2'b00, ST_OK, 48'h0});
    start = rsp_cnt;
    issue(OP_RESET, 2'd0, 40'h0);
    wait_rsp(start, 300);

    // Illegal op: response in the cycle after accept, pins untouched
    rsp_q.push_back({2'b00, ST_BAD, 48'h0});
    start = rsp_cnt; chg0 = pin_chg;
    issue(3'd7, 2'd1, 40'h0);
    wait_rsp(start, 20);
    check("ill_latency", 64'(rsp_cyc - acc_cyc + 1), 64'h1);
    check("ill_pin_chg", 64'(pin_chg - chg0), 64'h0);

    // SET_MODE 1 with AUX low -> AUX timeout after settle + timeout
    AUX = 1'b0;
    step(4);
    rsp_q.push_back({2'b01, ST_AUX_TO, 48'h0});
    start = rsp_cnt;
    issue(OP_SET_MODE, 2'd1, 40'h0);
    wait_rsp(start, SETTLE + AUX_TO + 50);
    lat = rsp_cyc - acc_cyc;
    check("sm1_aux_to_latency", 64'(lat >= SETTLE + AUX_TO && lat <= SETTLE + AUX_TO + 3), 64'h1);

    // Reset mid-operation aborts without a response
    AUX = 1'b1;
    step(4);
    start = rsp_cnt;
    issue(OP_SET_MODE, 2'd2, 40'h0);
    step(5);
    check("abort_pins_mid", 64'({M1, M0}), 64'h2);
    rst = 1'b1;
    step(2);
    check("abort_pins_rst",  64'({M1, M0}), 64'h3);
    check("abort_busy",      64'(busy),      64'h0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'h1);
    rst = 1'b0;
    step(20);
    check("abort_no_rsp", 64'(rsp_cnt), 64'(start));

    check("tx_queue_empty",  64'(tx_q.size()),  64'h0);
    check("rsp_queue_empty", 64'(rsp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_host_controller.md
Name: rf_host_controller

Overview:
Host-side initiator for the RF transceiver's MCU interface. It drives M0/M1, watches AUX, and runs the command byte sequences over an external UART byte channel: mode switch, write config (C0/C2), read config (C1), read version (C3) and reset (C4). It checks the response header, returns the result to a local command port, and restores the prior operating mode after every programming operation.

Parameters:
DEFAULT_MODE, 3, mode driven on M1:M0 out of reset
SETTLE_CYCLES, 31250, fixed wait after M pins change, before AUX is sampled
AUX_TIMEOUT, 1250000, maximum cycles to wait for synchronised AUX high
RX_TIMEOUT, 625000, maximum idle cycles between response bytes; restarts on each byte

Ports:
internal_clk  in  1  the single clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high
cmd_op  in  3  0 SET_MODE, 1 WRITE_CFG_SAVE, 2 WRITE_CFG_VOL, 3 READ_CFG, 4 READ_VERSION, 5 RESET, 6-7 illegal
cmd_mode  in  2  target mode for SET_MODE, as {M1,M0}
cmd_cfg  in  40  ADDH,ADDL,SPED,CHAN,OPTION; ADDH in [39:32]
tx_data  out  8  byte to the UART transmitter
tx_valid  out  1  byte valid; held with tx_data stable until tx_ready
tx_ready  in  1  UART transmitter accepts the byte
rx_data  in  8  byte from the UART receiver
rx_valid  in  1  one-cycle strobe per received byte
M0  out  1  mode pin
M1  out  1  mode pin
AUX  in  1  asynchronous transceiver busy/ready pin (1 = ready)
rsp_valid  out  1  one-cycle completion pulse
rsp_status  out  2  0 OK, 1 AUX timeout, 2 RX timeout, 3 bad header or illegal op
rsp_data  out  48  response bytes; first byte received in [47:40]; unused low bytes are 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: {M1,M0}=DEFAULT_MODE, cmd_ready=1, tx_valid=0, tx_data=0, rsp_valid=0, rsp_status=0, rsp_data=0, busy=0. Reset asserted mid-operation aborts the operation immediately; no rsp_valid pulse is produced.
- AUX passes through a 2-flop synchroniser before use. All AUX timing below refers to the synchronised signal.
- A single down-counter, wide enough for the largest of the three timing parameters, serves settle, AUX timeout and RX timeout.
- States: IDLE, SWITCH, WAIT_AUX, SEND, RECV, RESTORE, DONE.
- IDLE: on accept, latch op, mode and cfg. An illegal op goes to DONE with status 3; rsp_valid rises 1 cycle after the accept.
- SWITCH: drive the target pins and load SETTLE_CYCLES, then go to WAIT_AUX. If the target equals the current mode, the pins do not change and the settle is skipped (go straight to WAIT_AUX).
- Programming ops (1-5) target mode 3 and save the pre-op mode first.
- WAIT_AUX: proceed when AUX=1. Reaching AUX_TIMEOUT goes to DONE with status 1; for a programming op it goes through RESTORE first.
- SEND byte lists:
  - WRITE_CFG_SAVE: C0 then cfg[39:0] MSB byte first (6 bytes).
  - WRITE_CFG_VOL: C2 then the same 5 cfg bytes.
  - READ_CFG: C1 C1 C1.
  - READ_VERSION: C3 C3 C3.
  - RESET: C4 C4 C4.
- SEND handshake: one byte moves per cycle where tx_valid and tx_ready are both high; back-to-back transfers are allowed.
- After SEND: READ_CFG expects 6 bytes, READ_VERSION expects 4 bytes (go to RECV). Write and RESET ops go to WAIT_AUX to wait for the transceiver to finish, then to RESTORE.
- RECV:
  - Bytes fill rsp_data from the top down.
  - rx_valid seen outside RECV is ignored.
  - First-byte mismatch (READ_CFG expects C0, READ_VERSION expects C3) sets status 3 but reception continues to the expected count or the timeout.
  - RX_TIMEOUT expiry sets status 2 (status 3 takes precedence if already set).
  - Then go to RESTORE.
- RESTORE: if the saved mode is not 3, switch back (settle, then AUX wait). An AUX timeout here sets status 1 only if status is still 0. Then go to DONE.
- DONE: pulse rsp_valid for 1 cycle; rsp_data and rsp_status stay stable until the next accept; return to IDLE.

Decomposition:
- Package rf_host_pkg: opcode constants, status codes, command bytes (C0-C4), expected response lengths, state encoding.
- Sub-module sync_2ff: the AUX synchroniser. Everything else stays in one module.

Test Plan:
- Assert rst for 2 cycles with AUX=1 -> M1=1, M0=1, cmd_ready=1, busy=0, tx_valid=0, rsp_valid=0.
- READ_VERSION in mode 3, AUX=1, bench replies C3 32 27 02 -> tx carries C3,C3,C3; rsp_data=48'hC33227020000, status 0; pins stay 11 and no settle period occurs.
- From mode 0, WRITE_CFG_VOL with cmd_cfg=40'h00001A1744 -> pins go to 11; after SETTLE_CYCLES plus the AUX rise, tx carries C2 00 00 1A 17 44 with tx_ready toggling; pins return to 00 after AUX; status 0.
- READ_CFG where the responder sends only 5 bytes -> status 2 RX_TIMEOUT cycles after the 5th byte; saved mode is restored before rsp_valid.
- SET_MODE to 1 with AUX held low -> M0=1, M1=0; status 1 after SETTLE_CYCLES plus AUX_TIMEOUT cycles.
- READ_CFG where the reply starts with C2 (6 bytes) -> status 3, rsp_data holds all 6 bytes. Separately, cmd_op=7 -> status 3 with rsp_valid exactly 1 cycle after accept and the pins unchanged.
